// File: rtl/sm4_iter_core.sv
// sm4_iter_core: iterative SM4 encrypt/decrypt engine. Applies ROUNDS_PER_CYCLE
// chained rounds per clock on a single 128-bit state register. It handles
// round-key ordering, the final reverse transform R and the valid/ready
// handshakes.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | iterating rounds, cnt counts iterations
// DONE  | result held on out_data, out_valid=1
module sm4_iter_core #(
  parameter int  ROUNDS_PER_CYCLE = 1,
  localparam int N_ITER = 32 / ((ROUNDS_PER_CYCLE > 0) ? ROUNDS_PER_CYCLE : 1),
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_decrypt,
  input  logic [127:0]  in_data,
  input  logic [1023:0] rk_all,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
    $error("sm4_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  // SM4 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] l_xform(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // {A,B,C,D} -> {B,C,D, A ^ T(B^C^D^key)}
  function automatic logic [127:0] sm4_round(input logic [127:0] s, input logic [31:0] k);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = s;
    return {b, c, d, a ^ l_xform(tau(b ^ c ^ d ^ k))};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     s_q, s_d;
  logic             mode_q, mode_d;
  logic [127:0]     out_q, out_d;

  logic [31:0]  rk [32];
  logic [127:0] stage [ROUNDS_PER_CYCLE+1];

  for (genvar i = 0; i < 32; i++) begin : g_rk
    assign rk[i] = rk_all[1023-32*i -: 32];
  end

  assign stage[0] = s_q;

  // Unrolled round chain; decrypt walks the key schedule backwards.
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [4:0] g_idx, k_idx;
    assign g_idx = 5'(32'(cnt_q) * 32'(ROUNDS_PER_CYCLE) + 32'(j));
    assign k_idx = mode_q ? (5'd31 - g_idx) : g_idx;
    assign stage[j+1] = sm4_round(stage[j], rk[k_idx]);
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  // Next-state logic: clear overrides everything, including a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    mode_d  = mode_q;
    out_d   = out_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_d     = in_data;
            mode_d  = in_decrypt;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          s_d = stage[ROUNDS_PER_CYCLE];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
            out_d   = {stage[ROUNDS_PER_CYCLE][31:0],  stage[ROUNDS_PER_CYCLE][63:32],
                       stage[ROUNDS_PER_CYCLE][95:64], stage[ROUNDS_PER_CYCLE][127:96]};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              s_d     = in_data;
              mode_d  = in_decrypt;
              cnt_d   = '0;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_sm4_iter_core.sv
// Testbench for sm4_iter_core: main instance at one round per cycle plus one
// instance per other legal unroll factor for the known-answer latency check.
module tb_sm4_iter_core;

  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam int NMAIN = 32;
  localparam int NX = 5;

  localparam logic [2047:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic          clk, rst_n, clear, in_valid, in_decrypt, out_ready;
  logic [127:0]  in_data;
  logic [1023:0] rk_all;
  logic          in_ready, out_valid;
  logic [127:0]  out_data;

  logic [NX-1:0] x_in_ready, x_out_valid;
  logic [127:0]  x_out_data [NX];

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] rk_m [32];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rise_seen = 0;

  sm4_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_data(in_data), .rk_all(rk_all), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar k = 0; k < NX; k++) begin : g_x
    sm4_iter_core #(.ROUNDS_PER_CYCLE(2**(k+1))) u_x (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(x_in_ready[k]),
      .in_decrypt(in_decrypt), .in_data(in_data), .rk_all(rk_all), .out_valid(x_out_valid[k]),
      .out_ready(out_ready), .out_data(x_out_data[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model of SM4 (key expansion and cipher).
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau_m(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = SB[2047 - 8*int'(x[31-8*i -: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] x);
    logic [31:0] b;
    b = tau_m(x);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] x);
    logic [31:0] b;
    b = tau_m(x);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_m[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk, input logic dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk_m[31-i] : rk_m[i]));
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score handshakes against the queue, advance past the edge.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (out_valid) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out_valid observed=1 expected=0");
      end
      if (sb_q.size() != 0) begin
        if (!rise_seen) begin
          rise_seen = 1'b1;
          chk("latency", 128'(cyc), 128'(sb_q[0].due));
        end
        if (out_ready) begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          rise_seen = 1'b0;
        end
      end
    end
    if (clear) begin
      sb_q.delete();
      rise_seen = 1'b0;
    end else if (in_valid && in_ready) begin
      sb_q.push_back('{model(in_data, in_decrypt), cyc + NMAIN + 1});
      acc = 1'b1;
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    bit a;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle(a);
    chk(tag, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    bit acc;
    bit ov_seen;
    int t0, prev;
    logic [NX-1:0] seen;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
    in_data = '0; out_ready = 1'b0; rk_all = '0;

    expand_key(PT);
    for (int i = 0; i < 32; i++) rk_all[1023-32*i -: 32] = rk_m[i];
    chk("model_rk0", 128'(rk_m[0]), 128'h f12186f9);
    chk("model_rk31", 128'(rk_m[31]), 128'h9124a012);
    chk("model_enc", model(PT, 1'b0), CT);
    chk("model_dec", model(CT, 1'b1), PT);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Encrypt known answer on every unroll factor, then backpressure.
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cycle(acc);
    chk("accept_idle", 128'(acc), 128'd1);
    t0 = acc_cyc;
    in_valid = 1'b0;
    seen = '0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      cycle(acc);
      for (int k = 0; k < NX; k++) begin
        if (x_out_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("x%0d_latency", 2**(k+1)), 128'(cyc), 128'(t0 + 32/(2**(k+1)) + 1));
          chk($sformatf("x%0d_data", 2**(k+1)), x_out_data[k], CT);
        end
      end
    end
    chk("x_all_done", 128'(seen), 128'h1f);
    chk("main_done", 128'(out_valid), 128'd1);

    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = PT ^ 128'(i);
      cycle(acc);
      chk("bp_no_accept", 128'(acc), 128'd0);
      chk("bp_out_data", out_data, CT);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end

    in_data = CT; in_decrypt = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("release_in_ready", 128'(in_ready), 128'd1);
    cycle(acc);
    chk("release_accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    drain("decrypt_drain");
    chk("decrypt_kat", out_data, PT);

    // Streaming alternating encrypt/decrypt with out_ready held high.
    prev = 0;
    for (int b = 0; b < 4; b++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_decrypt = b[0];
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) cycle(acc);
      chk("stream_accept", 128'(acc), 128'd1);
      if (b > 0) chk("stream_spacing", 128'(acc_cyc - prev), 128'(NMAIN + 1));
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // clear during RUN at cnt=5, then clear with a handshake offered in IDLE.
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1;
    cycle(acc);
    chk("clr_accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    repeat (5) cycle(acc);
    clear = 1'b1; in_valid = 1'b1;
    cycle(acc);
    chk("clr_in_ready", 128'(in_ready), 128'd1);
    chk("clr_out_valid", 128'(out_valid), 128'd0);
    cycle(acc);
    clear = 1'b0; in_valid = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(acc);
      if (out_valid) ov_seen = 1'b1;
    end
    chk("clr_quiet", 128'(ov_seen), 128'd0);
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_decrypt = 1'b0; in_valid = 1'b1;
    cycle(acc);
    chk("clr_next_accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    drain("clr_next_drain");

    // Asynchronous reset in the middle of RUN.
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1;
    cycle(acc);
    chk("rst_accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    repeat (7) cycle(acc);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    sb_q.delete();
    rise_seen = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 128'(out_valid), 128'd0);
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1;
    cycle(acc);
    chk("post_rst_accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    drain("post_rst_drain");
    chk("post_rst_kat", out_data, CT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
